// File: rtl/send_arbiter_pkg.sv
// ============================================================================
//  Module   : send_arbiter_pkg
//  Desc     : Shared types and helpers for the send_arbiter block.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package send_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER   = 2'd1,
        COMMIT = 2'd2
    } arb_state_t;

    function automatic int maxlen(input int len_bits);
        return (1 << len_bits) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/send_arbiter_rr_pick.sv
// ============================================================================
//  Module   : send_arbiter_rr_pick
//  Desc     : Combinational round-robin pick: first set request at or after ptr.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module send_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    int                j;
    logic [IDXW-1:0]   jj;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        jj     = '0;
        for (int k = 0; k < NREQ; k++) begin
            // wrap explicitly so non-power-of-two NREQ works
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            jj = IDXW'(j);
            if (!any && req[jj]) begin
                any        = 1'b1;
                onehot[jj] = 1'b1;
                idx        = jj;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/send_arbiter.sv
// ============================================================================
//  Module   : send_arbiter
//  Desc     : Packet-atomic round-robin arbiter feeding send_ring / send_fifo.
//             Optional per-requester packet counters: SEND_ARB_STATS_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module send_arbiter
    import send_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int LEN_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [8*NREQ-1:0]     req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    output logic [7:0]            send_ring_data,
    output logic                  send_ring_wr_en,
    input  logic                  send_ring_full,
    output logic [LEN_BITS-1:0]   send_fifo_data,
    output logic                  send_fifo_wr_en,
    input  logic                  send_fifo_full,
    output logic [NREQ-1:0]       grant,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic [16*NREQ-1:0]    pkt_count
);

    localparam int                 IDXW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [LEN_BITS-1:0] MAXLEN = LEN_BITS'(maxlen(LEN_BITS));

    arb_state_t          state;
    arb_state_t          state_next;
    logic [IDXW-1:0]     owner;
    logic [IDXW-1:0]     rr_ptr;
    logic [IDXW-1:0]     rr_next;
    logic [LEN_BITS-1:0] count;

    logic [NREQ-1:0]     pick_onehot;
    logic [IDXW-1:0]     pick_idx;
    logic                pick_any;

    logic                cur_valid;
    logic                cur_last;
    logic [7:0]          cur_byte;
    logic                take_grant;
    logic                accept;
    logic                write_byte;
    logic                drop;
    logic                do_commit;

    send_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_byte  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == IDXW'(i)) begin
                cur_valid = req_valid[i];
                cur_last  = req_last[i];
                cur_byte  = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_next = state;
        take_grant = 1'b0;
        accept     = 1'b0;
        do_commit  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    take_grant = 1'b1;
                    state_next = XFER;
                end
            end
            XFER: begin
                if (cur_valid && !send_ring_full) begin
                    accept = 1'b1;
                    if (cur_last) begin
                        state_next = COMMIT;
                    end
                end
            end
            COMMIT: begin
                if (!send_fifo_full) begin
                    do_commit  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bytes beyond MAXLEN are handshaken but discarded so ring and length agree.
    assign write_byte = accept && (count != MAXLEN);
    assign drop       = accept && (count == MAXLEN);
    assign rr_next    = (owner == IDXW'(NREQ - 1)) ? '0 : owner + 1'b1;
    assign req_ready  = (state == XFER && !send_ring_full) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            grant           <= '0;
            owner           <= '0;
            rr_ptr          <= '0;
            count           <= '0;
            send_ring_data  <= '0;
            send_ring_wr_en <= 1'b0;
            send_fifo_data  <= '0;
            send_fifo_wr_en <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            state           <= state_next;
            send_ring_wr_en <= write_byte;
            send_fifo_wr_en <= do_commit;
            if (take_grant) begin
                grant <= pick_onehot;
                owner <= pick_idx;
            end
            if (write_byte) begin
                send_ring_data <= cur_byte;
                count          <= count + 1'b1;
            end
            if (do_commit) begin
                send_fifo_data <= count;
                count          <= '0;
                rr_ptr         <= rr_next;
                grant          <= '0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef SEND_ARB_STATS_EN
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat_lane
        logic [15:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (do_commit && owner == IDXW'(gi)) begin
                cnt <= cnt + 16'd1;
            end
        end
        assign pkt_count[16*gi +: 16] = cnt;
    end
`else
    assign pkt_count = '0;
`endif

endmodule

`default_nettype wire
